// File: rtl/imem_loader.sv
// Streams bytes into an instruction memory through a registered byte-write port, big-endian per word.
// Define IMEM_LOADER_CHECKSUM_EN to add a CHECK state that consumes one trailing XOR checksum byte.
module imem_loader #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned CNT_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_words,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  words_loaded
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {StIdle, StLoad, StCheck} state_e;
`else
  typedef enum logic [0:0] {StIdle, StLoad} state_e;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [CNT_W-1:0]  words_loaded_q, words_loaded_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              done_q, done_d;
  logic              accept;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic              err_q, err_d;
  logic [7:0]        xor_q, xor_d;
`endif

  assign in_ready = (state_q != StIdle) && !abort;
  assign accept   = in_ready && in_valid;

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    count_d        = count_q;
    byte_idx_d     = byte_idx_q;
    words_loaded_d = words_loaded_q;
    mem_we_d       = 1'b0;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    done_d         = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    err_d          = err_q;
    xor_d          = xor_q;
`endif
    case (state_q)
      StIdle: begin
        // abort has priority over start in IDLE
        if (start && !abort) begin
          if (num_words != '0) begin
            state_d        = StLoad;
            addr_d         = {base_addr[ADDR_W-1:2], 2'b00};
            count_d        = num_words;
            byte_idx_d     = 2'd0;
            words_loaded_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            err_d          = 1'b0;
            xor_d          = 8'h00;
`endif
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StLoad: begin
        if (abort) begin
          state_d = StIdle;
        end else if (accept) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = in_data;
          addr_d      = addr_q + ADDR_W'(1);
          byte_idx_d  = byte_idx_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          xor_d       = xor_q ^ in_data;
`endif
          if (byte_idx_q == 2'd3) begin
            words_loaded_d = words_loaded_q + CNT_W'(1);
            if (words_loaded_q == count_q - CNT_W'(1)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_d = StCheck;
`else
              state_d = StIdle;
              done_d  = 1'b1;
`endif
            end
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      StCheck: begin
        if (abort) begin
          state_d = StIdle;
        end else if (accept) begin
          err_d   = (in_data != xor_q);
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      addr_q         <= '0;
      count_q        <= '0;
      byte_idx_q     <= 2'd0;
      words_loaded_q <= '0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= 8'h00;
      done_q         <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      err_q          <= 1'b0;
      xor_q          <= 8'h00;
`endif
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      count_q        <= count_d;
      byte_idx_q     <= byte_idx_d;
      words_loaded_q <= words_loaded_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      done_q         <= done_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      err_q          <= err_d;
      xor_q          <= xor_d;
`endif
    end
  end

  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign busy         = (state_q != StIdle);
  assign done         = done_q;
  assign words_loaded = words_loaded_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign err          = err_q;
`else
  assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected writes queued at acceptance, checked on mem_we.
module tb_imem_loader;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned CNT_W  = 6;

  logic              clk = 1'b0;
  logic              reset, start, abort, in_valid, in_ready;
  logic [ADDR_W-1:0] base_addr, mem_addr;
  logic [CNT_W-1:0]  num_words, words_loaded;
  logic [7:0]        in_data, mem_wdata;
  logic              mem_we, busy, done, err;

  imem_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .num_words(num_words),
    .abort(abort), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done),
    .err(err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    int         cyc;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] exp_addr;
  int tests = 0, fails = 0, cyc = 0, n_writes = 0, n_done = 0, w0, d0;
  logic [7:0] seq_a[12] = '{8'h01, 8'h4A, 8'h18, 8'h20, 8'h00, 8'h4D, 8'h58, 8'h20,
                            8'h00, 8'h0D, 8'h4A, 8'h02};

  wire [26:0] outs = {mem_we, mem_addr, mem_wdata, busy, done, err, words_loaded, in_ready};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard side: every write must match the oldest queued acceptance
  always @(negedge clk) begin
    wr_t e;
    if (!reset && done) n_done++;
    if (!reset && mem_we) begin
      n_writes++;
      check("write_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wr_addr", mem_addr, e.addr);
        check("wr_data", mem_wdata, e.data);
        check("wr_latency", cyc, e.cyc);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] base, input logic [CNT_W-1:0] n);
    base_addr = base;
    num_words = n;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    exp_addr  = {base[7:2], 2'b00};
  endtask

  // Leaves in_valid high so consecutive calls stream back-to-back
  task automatic send(input logic [7:0] b, input bit is_data);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (in_ready) begin
        if (is_data) begin
          exp_q.push_back('{addr: exp_addr, data: b, cyc: cyc + 1});
          exp_addr = exp_addr + 8'd1;
        end
        ok = 1'b1;
      end
      tick();
    end
    check("accept_in_time", ok, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    base_addr = 8'h00; num_words = '0; exp_addr = 8'h00;
    repeat (2) tick();
    check("reset_outs", outs, 0);
    reset = 1'b0;
    tick();

    // Three words back-to-back from address 0
    w0 = n_writes; d0 = n_done;
    do_start(8'h00, 6'd3);
    check("A_busy", busy, 1);
    check("A_ready", in_ready, 1);
    foreach (seq_a[i]) send(seq_a[i], 1'b1);
    check("A_done", done, 1);
    check("A_words", words_loaded, 3);
    check("A_busy_after", busy, 0);
    in_valid = 1'b0;
    tick();
    check("A_done_pulses", n_done - d0, 1);
    check("A_writes", n_writes - w0, 12);
    check("A_queue_empty", exp_q.size(), 0);

    // Unaligned base near the top, address wraps
    w0 = n_writes;
    do_start(8'hFD, 6'd2);
    for (int i = 0; i < 8; i++) send(8'h10 + 8'(i), 1'b1);
    check("B_words", words_loaded, 2);
    check("B_done", done, 1);
    in_valid = 1'b0;
    tick();
    check("B_writes", n_writes - w0, 8);
    check("B_queue_empty", exp_q.size(), 0);

    // in_valid only every third cycle
    w0 = n_writes; d0 = n_done;
    do_start(8'h40, 6'd1);
    for (int i = 0; i < 4; i++) begin
      send(8'hA0 + 8'(i), 1'b1);
      in_valid = 1'b0;
      check("C_words_mid", words_loaded, (i == 3) ? 1 : 0);
      tick();
      tick();
    end
    check("C_writes", n_writes - w0, 4);
    check("C_done_pulses", n_done - d0, 1);

    // Abort after five bytes; a start mid-load is ignored
    w0 = n_writes; d0 = n_done;
    do_start(8'h80, 6'd4);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        base_addr = 8'h10; num_words = 6'd1; start = 1'b1;
      end
      send(8'hC0 + 8'(i), 1'b1);
      start = 1'b0;
    end
    in_data = 8'hEE;
    abort   = 1'b1;
    #1;
    check("D_ready_abort", in_ready, 0);
    tick();
    abort    = 1'b0;
    in_valid = 1'b0;
    check("D_busy", busy, 0);
    check("D_words", words_loaded, 1);
    repeat (2) tick();
    check("D_writes", n_writes - w0, 5);
    check("D_no_done", n_done - d0, 0);
    check("D_queue_empty", exp_q.size(), 0);

    // Zero-word start pulses done only
    do_start(8'h00, 6'd0);
    check("E_done", done, 1);
    check("E_busy", busy, 0);
    tick();
    check("E_done_clear", done, 0);

    // abort wins over start in IDLE
    num_words = 6'd2; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("F_busy", busy, 0);
    check("F_done", done, 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    for (int k = 0; k < 2; k++) begin
      w0 = n_writes; d0 = n_done;
      do_start(8'h00, 6'd1);
      send(8'h01, 1'b1); send(8'h02, 1'b1); send(8'h04, 1'b1); send(8'h08, 1'b1);
      check("G_check_busy", busy, 1);
      check("G_check_nodone", done, 0);
      send((k == 0) ? 8'h0F : 8'h0E, 1'b0);
      in_valid = 1'b0;
      check("G_done", done, 1);
      check("G_err", err, k);
      tick();
      check("G_writes", n_writes - w0, 4);
    end
`else
    check("err_const", err, 0);
`endif

    // Asynchronous reset mid-word, between edges
    do_start(8'h20, 6'd2);
    send(8'hAA, 1'b1);
    send(8'hBB, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("H_reset_outs", outs, 0);
    exp_q.delete();
    w0 = n_writes;
    tick();
    reset    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h77;
    repeat (4) tick();
    in_valid = 1'b0;
    check("H_no_writes", n_writes - w0, 0);
    check("H_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_W, default 8: byte-address width; target memory holds 2^ADDR_W bytes.
REQ-002 Parameter CNT_W, default 6: width of word-count input and counter.
REQ-003 Port clk  input  1: single clock; all state updates on rising edge.
REQ-004 Port reset  input  1: asynchronous, active-high reset.
REQ-005 Port start  input  1: one-cycle request to begin a load; sampled only in IDLE.
REQ-006 Port base_addr  input  ADDR_W: load start address; bits [1:0] ignored (forced word-aligned).
REQ-007 Port num_words  input  CNT_W: number of 32-bit instructions to load; 0 means zero words.
REQ-008 Port abort  input  1: cancels a load in progress.
REQ-009 Port in_valid / in_ready / in_data  input / output / input  1/1/8: byte stream; transfer when in_valid and in_ready both high.
REQ-010 Port mem_we / mem_addr / mem_wdata  output  1/ADDR_W/8: registered byte-write port to the instruction memory.
REQ-011 Port busy / done / err  output  1/1/1: load active; one-cycle completion pulse; checksum mismatch flag.
REQ-012 Port words_loaded  output  CNT_W: count of complete words written in the current/last load.

Function
- REQ-013 States SHALL be IDLE, LOAD, CHECK (CHECK present only with the macro).
- REQ-014 IDLE + start + num_words!=0 SHALL go to LOAD next cycle, latch base/count, clear words_loaded and err; start with num_words==0 SHALL pulse done next cycle, stay IDLE.
- REQ-015 start outside IDLE SHALL be ignored.
- REQ-016 in_ready SHALL be 1 only in LOAD/CHECK with abort low; 0 in IDLE.
- REQ-017 Each accepted data byte SHALL appear on mem_we=1, mem_wdata=byte, mem_addr=base+index exactly one cycle later (latency 1); mem_we=0 otherwise.
- REQ-018 Stream order SHALL equal ascending address order, so the first byte of each word is the instruction MSB (big-endian, matching fetch order).
- REQ-019 Address SHALL wrap modulo 2^ADDR_W (0xFF+1 -> 0x00).
- REQ-020 words_loaded SHALL increment in the cycle the 4th byte of a word is written.
- REQ-021 in_valid gaps SHALL stall progress with no writes and no state change.
- REQ-022 After the last data byte is accepted: without macro, go IDLE and pulse done in the cycle its write occurs; with macro, go CHECK.
- REQ-023 busy SHALL be 1 in LOAD and CHECK, 0 in IDLE.
- REQ-024 abort in LOAD/CHECK SHALL return to IDLE next cycle, accept no byte that cycle, no done pulse; a write from a byte accepted the prior cycle still completes.
- REQ-025 abort and start together in IDLE: abort wins, no load begins.

Reset
- REQ-026 Asserting reset SHALL immediately force IDLE, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, words_loaded=0, in_ready=0.
- REQ-027 Reset mid-load SHALL discard the load; no pending write issues after release.

Configuration
- REQ-028 Macro IMEM_LOADER_CHECKSUM_EN defined: XOR of all data bytes accumulated; in CHECK one extra byte accepted (not written to memory), err=1 if it differs from the XOR, else 0; done pulses the cycle after acceptance either way.
- REQ-029 Macro undefined: no CHECK state, no checksum byte consumed, err constant 0.

Verification
- REQ-030 base=0x00, num_words=3, bytes 01 4A 18 20 00 4D 58 20 00 0D 4A 02 back-to-back -> 12 writes addr 0x00..0x0B in order, words_loaded=3, one done pulse, busy low after.
- REQ-031 base=0xFD (aligned to 0xFC), num_words=2 -> write addrs FC FD FE FF 00 01 02 03.
- REQ-032 in_valid high every 3rd cycle, num_words=1 -> exactly 4 writes, each one cycle after its acceptance, no writes in gap cycles.
- REQ-033 abort after 5 accepted bytes of num_words=4 -> 5 writes total, words_loaded=1, busy low next cycle, no done; start during load ignored.
- REQ-034 With IMEM_LOADER_CHECKSUM_EN, bytes 01 02 04 08 then 0x0F -> err=0, done; repeat with 0x0E -> err=1, done; checksum byte never on mem_we.
- REQ-035 Reset asserted mid-word (async, between edges) -> all outputs at reset values immediately, no further writes.
